// File: rtl/lcd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : lcd_pkg                                              |
// | Description : Raster timing defaults, pack layout and unpack helper|
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
package lcd_pkg;

    localparam int H_ACTIVE_DEF = 800;
    localparam int H_FRONT_DEF  = 40;
    localparam int H_SYNC_DEF   = 128;
    localparam int H_BACK_DEF   = 88;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF  = 1;
    localparam int V_SYNC_DEF   = 3;
    localparam int V_BACK_DEF   = 21;

    localparam int H_TOTAL = H_SYNC_DEF + H_BACK_DEF + H_ACTIVE_DEF + H_FRONT_DEF;
    localparam int V_TOTAL = V_SYNC_DEF + V_BACK_DEF + V_ACTIVE_DEF + V_FRONT_DEF;

    localparam int PIX_W    = 10;
    localparam int PK_G_HI  = 14;
    localparam int PK_G_LO  = 10;
    localparam int PK_CH_HI = 9;
    localparam int PK_CH_LO = 0;

    typedef struct packed {
        logic [PIX_W-1:0] red;
        logic [PIX_W-1:0] green;
        logic [PIX_W-1:0] blue;
    } rgb_t;

    // rd1 carries G[9:5] and B, rd2 carries G[4:0] and R; bit 15 is spare.
    function automatic rgb_t unpack_pair(input logic [15:0] rd1, input logic [15:0] rd2);
        rgb_t p;
        p.red   = rd2[PK_CH_HI:PK_CH_LO];
        p.green = {rd1[PK_G_HI:PK_G_LO], rd2[PK_G_HI:PK_G_LO]};
        p.blue  = rd1[PK_CH_HI:PK_CH_LO];
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_frame_reader_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : lcd_frame_reader_if                                  |
// | Description : Read-FIFO side and LCD pin side of the frame reader  |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
interface lcd_frame_reader_if;

    logic [15:0] iRd1_data;
    logic [15:0] iRd2_data;
    logic        iRdEmpty;
    logic        oRdReq;
    logic        oFrameStart;
    logic        oHsync_n;
    logic        oVsync_n;
    logic        oDE;
    logic [9:0]  oRed;
    logic [9:0]  oGreen;
    logic [9:0]  oBlue;
    logic        oUnderflow;

    modport master (
        input  iRd1_data, iRd2_data, iRdEmpty,
        output oRdReq, oFrameStart, oHsync_n, oVsync_n, oDE,
               oRed, oGreen, oBlue, oUnderflow
    );

    modport slave (
        output iRd1_data, iRd2_data, iRdEmpty,
        input  oRdReq, oFrameStart, oHsync_n, oVsync_n, oDE,
               oRed, oGreen, oBlue, oUnderflow
    );

endinterface
`default_nettype wire

// File: rtl/lcd_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : lcd_timing_gen                                       |
// | Description : Raster counters with active/sync/frame-start decode  |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module lcd_timing_gen
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FRONT  = H_FRONT_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FRONT  = V_FRONT_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF
) (
    input  logic iClk,
    input  logic iRst,
    output logic act0_o,
    output logic hs0_o,
    output logic vs0_o,
    output logic frame_start_o
);

    localparam int HT  = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int VT  = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int HW  = (HT > 1) ? $clog2(HT) : 1;
    localparam int VW  = (VT > 1) ? $clog2(VT) : 1;
    localparam int HA0 = H_SYNC + H_BACK;
    localparam int VA0 = V_SYNC + V_BACK;

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic          h_act, v_act;

    always_comb begin
        hcnt_d = hcnt_q + 1'b1;
        vcnt_d = vcnt_q;
        if (hcnt_q == HW'(HT - 1)) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == VW'(VT - 1)) ? '0 : vcnt_q + 1'b1;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign h_act  = (hcnt_q >= HW'(HA0)) && (hcnt_q <= HW'(HA0 + H_ACTIVE - 1));
    assign v_act  = (vcnt_q >= VW'(VA0)) && (vcnt_q <= VW'(VA0 + V_ACTIVE - 1));
    assign act0_o = h_act && v_act;
    assign hs0_o  = (hcnt_q < HW'(H_SYNC));
    assign vs0_o  = (vcnt_q < VW'(V_SYNC));

    // Counters sit at 0/0 while reset is held; keep the pulse quiet until release.
    assign frame_start_o = (hcnt_q == '0) && (vcnt_q == '0) && !iRst;

endmodule
`default_nettype wire

// File: rtl/lcd_frame_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : lcd_frame_reader                                     |
// | Description : LCD raster timing, FIFO pop and pixel-pair unpack    |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module lcd_frame_reader
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FRONT  = H_FRONT_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FRONT  = V_FRONT_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF
) (
    input  logic                      iClk,
    input  logic                      iRst,
    lcd_frame_reader_if.master        bus
);

    logic act0, hs0, vs0, frame_start, miss0;
    logic act1_q, hs1_q, vs1_q, miss1_q;
    logic de_q, hsync_n_q, vsync_n_q;
    logic underflow_q, underflow_d;
    rgb_t pix_q, pix_d;

    lcd_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FRONT  (H_FRONT),
        .H_SYNC   (H_SYNC),
        .H_BACK   (H_BACK),
        .V_ACTIVE (V_ACTIVE),
        .V_FRONT  (V_FRONT),
        .V_SYNC   (V_SYNC),
        .V_BACK   (V_BACK)
    ) u_timing (
        .iClk          (iClk),
        .iRst          (iRst),
        .act0_o        (act0),
        .hs0_o         (hs0),
        .vs0_o         (vs0),
        .frame_start_o (frame_start)
    );

    assign miss0 = act0 & bus.iRdEmpty;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            act1_q  <= 1'b0;
            hs1_q   <= 1'b0;
            vs1_q   <= 1'b0;
            miss1_q <= 1'b0;
        end else begin
            act1_q  <= act0;
            hs1_q   <= hs0;
            vs1_q   <= vs0;
            miss1_q <= miss0;
        end
    end

    // FIFO words are present in stage 1; a skipped pop leaves stale data, so it goes black.
    always_comb begin
        pix_d = '0;
        if (act1_q && !miss1_q) begin
            pix_d = unpack_pair(bus.iRd1_data, bus.iRd2_data);
        end
    end

    always_comb begin
        underflow_d = underflow_q;
        if (frame_start) underflow_d = 1'b0;
        if (miss0)       underflow_d = 1'b1;
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            de_q        <= 1'b0;
            hsync_n_q   <= 1'b1;
            vsync_n_q   <= 1'b1;
            pix_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            de_q        <= act1_q;
            hsync_n_q   <= ~hs1_q;
            vsync_n_q   <= ~vs1_q;
            pix_q       <= pix_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.oRdReq      = act0 & ~bus.iRdEmpty;
    assign bus.oFrameStart = frame_start;
    assign bus.oHsync_n    = hsync_n_q;
    assign bus.oVsync_n    = vsync_n_q;
    assign bus.oDE         = de_q;
    assign bus.oRed        = pix_q.red;
    assign bus.oGreen      = pix_q.green;
    assign bus.oBlue       = pix_q.blue;
    assign bus.oUnderflow  = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_frame_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_lcd_frame_reader                                  |
// | Description : Scoreboard bench for lcd_frame_reader, small raster  |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module tb_lcd_frame_reader;

    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;

    typedef struct packed {
        logic       de;
        logic       hs_n;
        logic       vs_n;
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
    } pins_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lcd_frame_reader_if bus ();

    lcd_frame_reader #(
        .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
    ) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus)
    );

    pins_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    th = 0, tv = 0;
    logic  uf_exp = 1'b0;
    int    pops = 0, hs_low = 0, vs_low = 0, fstarts = 0;

    function automatic pins_t pins_now();
        pins_t p;
        p.de   = bus.oDE;
        p.hs_n = bus.oHsync_n;
        p.vs_n = bus.oVsync_n;
        p.r    = bus.oRed;
        p.g    = bus.oGreen;
        p.b    = bus.oBlue;
        return p;
    endfunction

    task automatic model_restart();
        th = 0;
        tv = 0;
        uf_exp = 1'b0;
        exp_q.delete();
    endtask

    // One pixel clock: drive empty flag, check stage-0 outputs, score pins, advance.
    task automatic cycle(input logic empty, input logic [15:0] w1, input logic [15:0] w2);
        logic act, hs, vs, fs, req, miss;
        logic [31:0] junk;
        pins_t e, got;
        bus.iRdEmpty = empty;
        #1;
        act  = (th >= HS + HB) && (th < HS + HB + HA) && (tv >= VS + VB) && (tv < VS + VB + VA);
        hs   = (th < HS);
        vs   = (tv < VS);
        fs   = (th == 0) && (tv == 0);
        req  = act && !empty;
        miss = act && empty;
        n_vec++;
        if (bus.oRdReq !== req) begin
            n_err++;
            $display("FAIL rdreq h=%0d v=%0d: got %b expected %b", th, tv, bus.oRdReq, req);
        end
        n_vec++;
        if (bus.oFrameStart !== fs) begin
            n_err++;
            $display("FAIL framestart h=%0d v=%0d: got %b expected %b", th, tv, bus.oFrameStart, fs);
        end
        n_vec++;
        if (bus.oUnderflow !== uf_exp) begin
            n_err++;
            $display("FAIL underflow h=%0d v=%0d: got %b expected %b", th, tv, bus.oUnderflow, uf_exp);
        end
        if (exp_q.size() == 2) begin
            e   = exp_q.pop_front();
            got = pins_now();
            n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL pins h=%0d v=%0d: got de=%b hs_n=%b vs_n=%b rgb=%h/%h/%h expected de=%b hs_n=%b vs_n=%b rgb=%h/%h/%h",
                         th, tv, got.de, got.hs_n, got.vs_n, got.r, got.g, got.b,
                         e.de, e.hs_n, e.vs_n, e.r, e.g, e.b);
            end
        end
        e.de   = act;
        e.hs_n = !hs;
        e.vs_n = !vs;
        e.r    = req ? w2[9:0] : 10'h0;
        e.g    = req ? {w1[14:10], w2[14:10]} : 10'h0;
        e.b    = req ? w1[9:0] : 10'h0;
        exp_q.push_back(e);
        pops    += int'(req);
        hs_low  += int'(!bus.oHsync_n);
        vs_low  += int'(!bus.oVsync_n);
        fstarts += int'(fs);
        @(posedge clk);
        if (miss)    uf_exp = 1'b1;
        else if (fs) uf_exp = 1'b0;
        if (th == HT - 1) begin
            th = 0;
            tv = (tv == VT - 1) ? 0 : tv + 1;
        end else begin
            th = th + 1;
        end
        #1;
        if (req) begin
            bus.iRd1_data = w1;
            bus.iRd2_data = w2;
        end else begin
            junk = $urandom;
            bus.iRd1_data = junk[15:0] | 16'h8001;
            bus.iRd2_data = junk[31:16] | 16'h8001;
        end
    endtask

    task automatic run_random(input int n);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            cycle(1'b0, w[15:0], w[31:16]);
        end
    endtask

    task automatic test_reset();
        logic [35:0] got;
        logic [35:0] rst_val;
        rst_val = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 30'h0, 1'b0};
        repeat (2) @(posedge clk);
        #1;
        got = {bus.oRdReq, bus.oFrameStart, bus.oHsync_n, bus.oVsync_n, bus.oDE,
               bus.oRed, bus.oGreen, bus.oBlue, bus.oUnderflow};
        n_vec++;
        if (got !== rst_val) begin
            n_err++;
            $display("FAIL reset_initial: got %h expected %h", got, rst_val);
        end
        rst = 1'b0;
        model_restart();
        // Run into line 2 with a miss on its first active pixel, then reset mid-line.
        for (int i = 0; i < 21; i++) begin
            cycle(i == 19, 16'h1234, 16'h0567);
        end
        n_vec++;
        if (bus.oDE !== 1'b1 || bus.oUnderflow !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_state: got de=%b uf=%b expected de=1 uf=1", bus.oDE, bus.oUnderflow);
        end
        rst = 1'b1;
        #1;
        got = {bus.oRdReq, bus.oFrameStart, bus.oHsync_n, bus.oVsync_n, bus.oDE,
               bus.oRed, bus.oGreen, bus.oBlue, bus.oUnderflow};
        n_vec++;
        if (got !== rst_val) begin
            n_err++;
            $display("FAIL reset_midline: got %h expected %h", got, rst_val);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_restart();
    endtask

    task automatic test_timing();
        int pops_f1;
        pops = 0; hs_low = 0; vs_low = 0; fstarts = 0;
        run_random(HT * VT);
        pops_f1 = pops;
        run_random(HT * VT);
        n_vec++;
        if (pops_f1 !== 12) begin
            n_err++;
            $display("FAIL pops_frame1: got %0d expected 12", pops_f1);
        end
        n_vec++;
        if (pops !== 24) begin
            n_err++;
            $display("FAIL pops_2frames: got %0d expected 24", pops);
        end
        n_vec++;
        if (fstarts !== 2) begin
            n_err++;
            $display("FAIL framestart_count: got %0d expected 2", fstarts);
        end
        n_vec++;
        if (hs_low !== 24) begin
            n_err++;
            $display("FAIL hsync_low_count: got %0d expected 24", hs_low);
        end
        n_vec++;
        if (vs_low !== 16) begin
            n_err++;
            $display("FAIL vsync_low_count: got %0d expected 16", vs_low);
        end
    endtask

    task automatic test_unpack(input logic [15:0] w1, input logic [15:0] w2, input string tag);
        int guard;
        for (int i = 0; i < HT * VT; i++) cycle(1'b0, w1, w2);
        guard = 0;
        while (bus.oDE !== 1'b1 && guard < 2 * HT * VT) begin
            cycle(1'b0, w1, w2);
            guard++;
        end
        n_vec++;
        if (bus.oDE !== 1'b1) begin
            n_err++;
            $display("FAIL %s_de_timeout: got de=%b expected 1", tag, bus.oDE);
        end
        n_vec++;
        if ({bus.oRed, bus.oGreen, bus.oBlue} !== {10'h3FF, 10'h2AA, 10'h155}) begin
            n_err++;
            $display("FAIL %s_rgb: got %h/%h/%h expected 3ff/2aa/155", tag, bus.oRed, bus.oGreen, bus.oBlue);
        end
    endtask

    task automatic test_underflow();
        logic [31:0] w;
        int guard;
        guard = 0;
        while (!(th == 0 && tv == 0) && guard < HT * VT) begin
            run_random(1);
            guard++;
        end
        pops = 0;
        for (int k = 0; k < HT * VT; k++) begin
            w = $urandom;
            cycle(k == 2 * HT + HS + HB + 1, w[15:0], w[31:16]);
        end
        n_vec++;
        if (pops !== 11) begin
            n_err++;
            $display("FAIL underflow_pops: got %0d expected 11", pops);
        end
        n_vec++;
        if (bus.oUnderflow !== 1'b1) begin
            n_err++;
            $display("FAIL underflow_sticky: got %b expected 1", bus.oUnderflow);
        end
        run_random(1);
        n_vec++;
        if (bus.oUnderflow !== 1'b0) begin
            n_err++;
            $display("FAIL underflow_clear: got %b expected 0", bus.oUnderflow);
        end
    endtask

    task automatic test_blanking();
        int leaks;
        leaks = 0;
        for (int i = 0; i < HT * VT; i++) begin
            run_random(1);
            if (bus.oDE === 1'b0 && {bus.oRed, bus.oGreen, bus.oBlue} !== 30'h0) leaks++;
        end
        n_vec++;
        if (leaks !== 0) begin
            n_err++;
            $display("FAIL blanking_rgb: got %0d nonblack blank pixels expected 0", leaks);
        end
    endtask

    initial begin
        bus.iRdEmpty  = 1'b0;
        bus.iRd1_data = 16'hFFFF;
        bus.iRd2_data = 16'hFFFF;
        test_reset();
        test_timing();
        test_unpack(16'h5555, 16'h2BFF, "unpack");
        test_unpack(16'hD555, 16'hABFF, "bit15");
        test_underflow();
        test_blanking();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
